// File: rtl/usr_pkg.sv
// Shared types for the universal shift register.
// Operation modes and control FSM states.
package usr_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

endpackage

// File: rtl/usr_step.sv
// Single-step next-value function of the shift register.
// In: mode, rotate, sin_r, sin_l, pi, po. Out: nxt.
module usr_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  mode_e             mode,
  input  logic              rotate,
  input  logic              sin_r,
  input  logic              sin_l,
  input  logic [WIDTH-1:0]  pi,
  input  logic [WIDTH-1:0]  po,
  output logic [WIDTH-1:0]  nxt
);

  logic fill_r;
  logic fill_l;

  assign fill_r = rotate ? po[0] : sin_r;
  assign fill_l = rotate ? po[WIDTH-1] : sin_l;

  always_comb begin
    nxt = po;
    unique case (mode)
      MODE_HOLD: nxt = po;
      MODE_SHR:  nxt = {fill_r, po[WIDTH-1:1]};
      MODE_SHL:  nxt = {po[WIDTH-2:0], fill_l};
      MODE_LOAD: nxt = pi;
      default:   nxt = po;
    endcase
  end

endmodule

// File: rtl/universal_shift_reg.sv
// WIDTH-bit hold/load/shift/rotate register with start/busy/done control.
// In: clk, clear_n, sync_clear, start, mode, rotate, count, pi, sin_r, sin_l.
// Out: po, sout_r, sout_l, busy, done.
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              sync_clear,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              rotate,
  input  logic [CNT_W-1:0]  count,
  input  logic [WIDTH-1:0]  pi,
  input  logic              sin_r,
  input  logic              sin_l,
  output logic [WIDTH-1:0]  po,
  output logic              sout_r,
  output logic              sout_l,
  output logic              busy,
  output logic              done
);

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic               rot_q, rot_d;
  logic [WIDTH-1:0]   pi_q, pi_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   po_q, po_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   step_nxt;
  logic               is_shift;

  usr_step #(.WIDTH(WIDTH)) u_step (
    .mode   (mode_q),
    .rotate (rot_q),
    .sin_r  (sin_r),
    .sin_l  (sin_l),
    .pi     (pi_q),
    .po     (po_q),
    .nxt    (step_nxt)
  );

  assign is_shift = (mode == MODE_SHR) || (mode == MODE_SHL);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    rot_d   = rot_q;
    pi_d    = pi_q;
    rem_d   = rem_q;
    po_d    = po_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (sync_clear) begin
      state_d = IDLE;
      po_d    = '0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            // a zero-count shift behaves as a one-step hold
            mode_d  = (is_shift && count == '0) ? MODE_HOLD : mode_e'(mode);
            rot_d   = rotate;
            pi_d    = pi;
            rem_d   = (is_shift && count != '0) ? count : CNT_W'(1);
            busy_d  = 1'b1;
            state_d = RUN;
          end
        end
        RUN: begin
          po_d  = step_nxt;
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      mode_q  <= MODE_HOLD;
      rot_q   <= 1'b0;
      pi_q    <= '0;
      rem_q   <= '0;
      po_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rot_q   <= rot_d;
      pi_q    <= pi_d;
      rem_q   <= rem_d;
      po_q    <= po_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign po     = po_q;
  assign sout_r = po_q[0];
  assign sout_l = po_q[WIDTH-1];
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
